// File: rtl/rv32_pkg.sv
// Shared RV32I writeback definitions: widths, result-select encoding, load funct3 codes.
package rv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = $clog2(NREGS);

  // Result select; encoding 2'b11 is reserved and behaves as RES_ALU.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension of a raw memory word.
module load_extend
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half; halfword offset bit 0 is ignored.
  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
  end

  // Extend according to load type; unused encodings act as LW.
  always_comb begin
    data_c = raw;
    case (funct3)
      F3_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_c = {24'h000000, byte_sel};
      F3_LH:   data_c = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_c = {16'h0000, half_sel};
      F3_LW:   data_c = raw;
      default: data_c = raw;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: MEM/WB register, result select, x0 suppression and
// load-use scoreboard driving the decode stall.
// Optional feature macro WB_BYPASS_EN: forward WD3 into decode and release the
// stall during the W cycle instead of after commit.
module writeback_unit
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic              StallW,
  input  logic              IssueLoadE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RD1D,
  input  logic [REG_AW-1:0] RD2D,
  output logic              RegWrite,
  output logic [REG_AW-1:0] RdD,
  output logic [XLEN-1:0]   WD3,
  output logic              HazardStallD,
  output logic              Bypass1D,
  output logic              Bypass2D
);

  logic [XLEN-1:0]  load_data_c;
  logic [XLEN-1:0]  result_c;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             byp1_c;
  logic             byp2_c;

  load_extend u_load_extend (
    .funct3 (Funct3M),
    .offset (ALUResultM[1:0]),
    .raw    (ReadDataM),
    .data_c (load_data_c)
  );

  // Result select; the reserved encoding falls through to the ALU result.
  always_comb begin
    result_c = ALUResultM;
    case (ResultSrcM)
      RES_LOAD: result_c = load_data_c;
      RES_PC4:  result_c = PCPlus4M;
      default:  result_c = ALUResultM;
    endcase
  end

  // MEM/WB register; x0 writes are dropped at capture, StallW freezes the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      RdD      <= '0;
      WD3      <= '0;
    end else if (!StallW) begin
      RegWrite <= ValidM & RegWriteM & (RdM != '0);
      RdD      <= RdM;
      WD3      <= result_c;
    end
  end

  // Scoreboard update: commit clears, a new load sets; set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (RegWrite && !StallW) busy_d[RdD] = 1'b0;
    if (IssueLoadE && (RdE != '0)) busy_d[RdE] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard flops.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef WB_BYPASS_EN
  // Writeback forwarding match per decode operand.
  always_comb begin
    byp1_c = RegWrite & (RdD == RD1D) & (RD1D != '0);
    byp2_c = RegWrite & (RdD == RD2D) & (RD2D != '0);
  end
`else
  // No forwarding path: decode waits for the regfile write to land.
  always_comb begin
    byp1_c = 1'b0;
    byp2_c = 1'b0;
  end
`endif

  // Load-use stall; busy_q[0] is always clear so x0 never stalls.
  always_comb begin
    Bypass1D     = byp1_c;
    Bypass2D     = byp2_c;
    HazardStallD = (busy_q[RD1D] & ~byp1_c) | (busy_q[RD2D] & ~byp2_c);
  end

endmodule
